idelay_eye_scanner: RTL and testbench

IDELAY_EYE_SCANNER -- requirements
Module: idelay_eye_scanner

---
 rtl/idelay_eye_scanner.sv | 209 ++++++++++++++++++++
 tb/tb_idelay_eye_scanner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_eye_scanner.sv
// IDELAYE2 eye scanner: sweeps all 32 taps over a toggling training pattern,
// finds the widest passing window and loads the tap at its centre.
module idelay_eye_scanner #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cal_rdy,
    input  logic       start,
    input  logic       sample_in,
    input  logic [4:0] dly_cntvalue_out,
    output logic       dly_ld,
    output logic [4:0] dly_cntvalue,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [4:0] best_tap,
    output logic [5:0] win_len,
    output logic       load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_DONE
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_tap;
    logic [4:0]    r_run_start;
    logic [4:0]    r_best_start;
    logic [4:0]    r_best_tap;
    logic [4:0]    r_cntvalue;
    logic [5:0]    r_run_len;
    logic [5:0]    r_best_len;
    logic [5:0]    r_win_len;
    logic          r_prev;
    logic          r_fail;
    logic          r_found;
    logic          r_load_err;

    logic          w_abort;
    logic          w_accept;
    logic          w_go;
    logic          w_settle_last;
    logic          w_sample_last;
    logic [5:0]    w_run_len_inc;
    logic [4:0]    w_run_start_eff;
    logic [4:0]    w_center;
    logic [4:0]    w_apply_tap;

    assign w_abort         = (r_state != S_IDLE) && !cal_rdy;
    assign w_accept        = (r_state == S_IDLE) && start && cal_rdy;
    assign w_go            = cal_rdy && rst_n;
    assign w_settle_last   = (r_cnt == CW'(SETTLE_CYCLES - 1));
    assign w_sample_last   = (r_cnt == CW'(SAMPLE_CYCLES - 1));
    assign w_run_len_inc   = r_run_len + 6'd1;
    assign w_run_start_eff = (r_run_len == 6'd0) ? r_tap : r_run_start;
    // best_len is 1..32 here, so the floor-centre offset fits in 5 bits.
    assign w_center        = r_best_start + 5'((r_best_len - 6'd1) >> 1);
    assign w_apply_tap     = (r_best_len != 6'd0) ? w_center : 5'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start && cal_rdy) w_next = S_LOAD;
            S_LOAD:   w_next = S_SETTLE;
            S_SETTLE: if (w_settle_last) w_next = S_SAMPLE;
            S_SAMPLE: if (w_sample_last) w_next = S_EVAL;
            S_EVAL:   w_next = (r_tap == 5'd31) ? S_APPLY : S_LOAD;
            S_APPLY:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // Loads are suppressed while aborting or in reset so no stray LD reaches the IDELAY.
    always_comb begin
        dly_ld       = 1'b0;
        dly_cntvalue = r_cntvalue;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_go) begin
                    dly_ld       = 1'b1;
                    dly_cntvalue = r_tap;
                end
            end
            S_APPLY: begin
                if (w_go) begin
                    dly_ld       = 1'b1;
                    dly_cntvalue = w_apply_tap;
                end
            end
            S_DONE: done = w_go;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_tap        <= 5'd0;
            r_run_start  <= 5'd0;
            r_best_start <= 5'd0;
            r_best_tap   <= 5'd0;
            r_cntvalue   <= 5'd0;
            r_run_len    <= 6'd0;
            r_best_len   <= 6'd0;
            r_win_len    <= 6'd0;
            r_prev       <= 1'b0;
            r_fail       <= 1'b0;
            r_found      <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            if (dly_ld) begin
                r_cntvalue <= dly_cntvalue;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt        <= '0;
                        r_tap        <= 5'd0;
                        r_run_start  <= 5'd0;
                        r_run_len    <= 6'd0;
                        r_best_start <= 5'd0;
                        r_best_len   <= 6'd0;
                        r_fail       <= 1'b0;
                        r_found      <= 1'b0;
                        r_load_err   <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_last) begin
                        r_cnt <= '0;
                        if (dly_cntvalue_out != r_tap) begin
                            r_load_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SAMPLE: begin
                    r_prev <= sample_in;
                    if ((r_cnt != '0) && (sample_in == r_prev)) begin
                        r_fail <= 1'b1;
                    end
                    if (w_sample_last) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_EVAL: begin
                    if (!r_fail) begin
                        r_run_len   <= w_run_len_inc;
                        r_run_start <= w_run_start_eff;
                        // Strict compare keeps the earlier window on a tie.
                        if (w_run_len_inc > r_best_len) begin
                            r_best_len   <= w_run_len_inc;
                            r_best_start <= w_run_start_eff;
                        end
                    end else begin
                        r_run_len <= 6'd0;
                    end
                    r_fail <= 1'b0;
                    if (r_tap != 5'd31) begin
                        r_tap <= r_tap + 5'd1;
                    end
                end
                S_APPLY: begin
                    if (cal_rdy) begin
                        r_best_tap <= w_apply_tap;
                        r_win_len  <= r_best_len;
                        r_found    <= (r_best_len != 6'd0);
                    end
                end
                default: ;
            endcase
            if (w_abort) begin
                r_cnt   <= '0;
                r_fail  <= 1'b0;
                r_found <= 1'b0;
            end
        end
    end

    assign found    = r_found;
    assign best_tap = r_best_tap;
    assign win_len  = r_win_len;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_idelay_eye_scanner.sv
// Directed bench for idelay_eye_scanner with a behavioural IDELAY/pattern model.
module tb_idelay_eye_scanner;

    localparam int SETTLE    = 4;
    localparam int SAMPLE    = 8;
    localparam int SWEEP_LAT = 450; // 32*(2+4+8)+2

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cal_rdy = 1'b0;
    logic       start = 1'b0;
    logic       sample_in = 1'b0;
    logic [4:0] dly_cntvalue_out = 5'd0;
    logic       dly_ld;
    logic [4:0] dly_cntvalue;
    logic       busy;
    logic       done;
    logic       found;
    logic [4:0] best_tap;
    logic [5:0] win_len;
    logic       load_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pass_mask = 32'h0;
    logic        err_en = 1'b0;
    logic [4:0]  err_tap = 5'd0;
    logic [4:0]  model_tap = 5'd0;
    logic        toggle = 1'b0;
    int          ld_count = 0;
    int          done_count = 0;
    logic [4:0]  last_ld = 5'd0;
    logic        prev_ld = 1'b0;
    logic        double_ld = 1'b0;

    always #5 clk = ~clk;

    idelay_eye_scanner #(
        .SETTLE_CYCLES(SETTLE),
        .SAMPLE_CYCLES(SAMPLE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cal_rdy          (cal_rdy),
        .start            (start),
        .sample_in        (sample_in),
        .dly_cntvalue_out (dly_cntvalue_out),
        .dly_ld           (dly_ld),
        .dly_cntvalue     (dly_cntvalue),
        .busy             (busy),
        .done             (done),
        .found            (found),
        .best_tap         (best_tap),
        .win_len          (win_len),
        .load_err         (load_err)
    );

    // IDELAY model: latches the tap on LD, data toggles on passing taps, stuck elsewhere.
    always @(negedge clk) begin
        if (dly_ld) begin
            model_tap = dly_cntvalue;
            ld_count++;
            last_ld = dly_cntvalue;
        end
        if (dly_ld && prev_ld) double_ld = 1'b1;
        prev_ld = dly_ld;
        if (done) done_count++;
        toggle = ~toggle;
        sample_in = pass_mask[model_tap] ? toggle : 1'b0;
        dly_cntvalue_out = (err_en && (model_tap == err_tap)) ? (model_tap ^ 5'd1) : model_tap;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_sweep(input logic [31:0] mask, input logic err_en_i,
                            input logic [4:0] err_tap_i, input logic poke_start,
                            output int lat);
        pass_mask  = mask;
        err_en     = err_en_i;
        err_tap    = err_tap_i;
        ld_count   = 0;
        done_count = 0;
        double_ld  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke_start) start = (lat == 100);
        end
        start = 1'b0;
    endtask

    task automatic check_sweep(input string pfx, input int lat, input logic exp_found,
                               input logic [4:0] exp_tap, input logic [5:0] exp_win,
                               input logic exp_err);
        check({pfx, "_latency"}, lat, SWEEP_LAT);
        check({pfx, "_found"}, found, exp_found);
        check({pfx, "_best_tap"}, best_tap, exp_tap);
        check({pfx, "_win_len"}, win_len, exp_win);
        check({pfx, "_load_err"}, load_err, exp_err);
        @(posedge clk);
        #1;
        check({pfx, "_done_pulse"}, done, 1'b0);
        check({pfx, "_idle"}, busy, 1'b0);
        check({pfx, "_done_count"}, done_count, 1);
        check({pfx, "_ld_count"}, ld_count, 33);
        check({pfx, "_last_ld"}, last_ld, exp_tap);
        check({pfx, "_cntvalue"}, dly_cntvalue, exp_tap);
        check({pfx, "_no_double_ld"}, double_ld, 1'b0);
    endtask

    task automatic wait_ld(input logic [4:0] tap, input string tag);
        int t;
        t = 0;
        while (!(dly_ld && dly_cntvalue == tap) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(tag, (t < 1000), 1'b1);
    endtask

    initial begin
        int lat;
        int n_ld;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_found", found, 1'b0);
        check("rst_best_tap", best_tap, 5'd0);
        check("rst_win_len", win_len, 6'd0);
        check("rst_load_err", load_err, 1'b0);
        check("rst_dly_ld", dly_ld, 1'b0);
        check("rst_cntvalue", dly_cntvalue, 5'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("start_no_cal", busy, 1'b0);
        cal_rdy = 1'b1;

        do_sweep(32'h000F_FF00, 1'b0, 5'd0, 1'b1, lat);
        check_sweep("win8_19", lat, 1'b1, 5'd13, 6'd12, 1'b0);

        do_sweep(32'h3FF0_003C, 1'b0, 5'd0, 1'b0, lat);
        check_sweep("two_win", lat, 1'b1, 5'd24, 6'd10, 1'b0);

        do_sweep(32'h0000_3C78, 1'b0, 5'd0, 1'b0, lat);
        check_sweep("tie", lat, 1'b1, 5'd4, 6'd4, 1'b0);

        do_sweep(32'h0000_0000, 1'b0, 5'd0, 1'b0, lat);
        check_sweep("all_fail", lat, 1'b0, 5'd0, 6'd0, 1'b0);

        do_sweep(32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, lat);
        check_sweep("all_pass", lat, 1'b1, 5'd15, 6'd32, 1'b0);

        do_sweep(32'h000F_FF00, 1'b1, 5'd7, 1'b0, lat);
        check_sweep("readback_err", lat, 1'b1, 5'd13, 6'd12, 1'b1);

        // Reset during tap 20 SETTLE.
        pass_mask = 32'h000F_FF00;
        err_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ld(5'd20, "rst_mid_reach");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        n_ld = ld_count;
        @(posedge clk);
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_found", found, 1'b0);
        check("rst_mid_best_tap", best_tap, 5'd0);
        check("rst_mid_win_len", win_len, 6'd0);
        check("rst_mid_load_err", load_err, 1'b0);
        check("rst_mid_cntvalue", dly_cntvalue, 5'd0);
        check("rst_mid_dly_ld", dly_ld, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_no_ld", ld_count, n_ld);
        do_sweep(32'h000F_FF00, 1'b0, 5'd0, 1'b0, lat);
        check_sweep("after_rst", lat, 1'b1, 5'd13, 6'd12, 1'b0);

        // cal_rdy drop during tap 10 SAMPLE.
        pass_mask = 32'hFFFF_FFFF;
        done_count = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ld(5'd10, "abort_reach");
        repeat (7) @(negedge clk);
        cal_rdy = 1'b0;
        n_ld = ld_count;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_found", found, 1'b0);
        check("abort_cntvalue", dly_cntvalue, 5'd10);
        @(negedge clk);
        cal_rdy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_count, 0);
        check("abort_no_ld", ld_count, n_ld);
        check("abort_still_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
